// File: rtl/mem8x8_pkg.sv
// Shared definitions for the 8x8 memory core: default geometry and FSM state encoding.
package mem8x8_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WR   = 2'b01,
    ST_RD   = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/mem8x8_array.sv
// Register-array storage with a per-word "written" vector; combinational read port.
module mem8x8_array
  import mem8x8_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_written;

  // Contents survive reset; validity is tracked solely by r_written.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_written <= '0;
    end else if (we) begin
      r_written[waddr] <= 1'b1;
    end
  end

  assign rdata  = r_mem[raddr];
  assign rvalid = r_written[raddr];

endmodule

// File: rtl/mem8x8_core.sv
// Request FSM for the 8x8 memory: accept, one write or read, then a done pulse.
module mem8x8_core
  import mem8x8_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              uninit
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_dout;
  logic              r_uninit_q;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;
  logic              w_rvalid;

  mem8x8_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (w_we),
    .waddr  (r_addr),
    .wdata  (r_din),
    .raddr  (r_addr),
    .rdata  (w_rdata),
    .rvalid (w_rvalid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The request type is captured by the WR/RD state itself, so rw needs no register.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (valid) w_next = rw ? ST_WR : ST_RD;
      ST_WR:   w_next = ST_DONE;
      ST_RD:   w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_we   = (r_state == ST_WR);
    busy   = (r_state != ST_IDLE);
    done   = (r_state == ST_DONE);
    uninit = (r_state == ST_DONE) && r_uninit_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_din  <= '0;
    end else if (r_state == ST_IDLE && valid) begin
      r_addr <= addr;
      r_din  <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout     <= '0;
      r_uninit_q <= 1'b0;
    end else if (r_state == ST_RD) begin
      r_dout     <= w_rvalid ? w_rdata : '0;
      r_uninit_q <= ~w_rvalid;
    end else if (r_state == ST_WR) begin
      r_uninit_q <= 1'b0;
    end
  end

  assign dout = r_dout;

endmodule
